dmem_ctrl: RTL

Access sequencer between the MEM stage and the dual-port data block RAM (registered read port, one-cycle read latency, single write-enable). It accepts one load/store request at a time, drives the RAM read and write ports, and performs byte/halfword stores as a two-cycle read-modify-write so untouched lanes are preserved. It also sign- or zero-extends load data by byte lane and returns a one-cycle response pulse that the pipeline uses to release its stall.

---
 rtl/dmem_pkg.sv | 46 ++++
 rtl/dmem_lane_unit.sv | 66 ++++++
 rtl/dmem_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access sequencer.
//   - funct codes for the load set (LB/LH/LW/LBU/LHU) and store set (SB/SH/SW)
//   - sequencer state enumeration
//   - helpers classifying a request as supported and/or misaligned
package dmem_pkg;

  // Load funct codes
  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  // Store funct codes
  localparam logic [2:0] F_SB  = 3'b000;
  localparam logic [2:0] F_SH  = 3'b001;
  localparam logic [2:0] F_SW  = 3'b010;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdData,
    StWr,
    StRmwRd,
    StRmwWr,
    StErr
  } state_e;

  function automatic logic funct_supported(input logic we, input logic [2:0] funct);
    if (we) begin
      return (funct == F_SB) || (funct == F_SH) || (funct == F_SW);
    end
    return (funct == F_LB) || (funct == F_LH) || (funct == F_LW) ||
           (funct == F_LBU) || (funct == F_LHU);
  endfunction

  // funct[1:0] encodes access size for every supported code: 00 byte, 01 half, 10 word.
  function automatic logic access_misaligned(input logic [2:0] funct, input logic [1:0] addr);
    unique case (funct[1:0])
      2'b01:   return addr[0];
      2'b10:   return addr != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: combinational byte-lane logic for the data-memory sequencer.
//   Loads : selects the byte/halfword lane of word and sign/zero-extends it (rdata_ext).
//           Unsupported load codes yield 0.
//   Stores: merges wdata into the addressed lane of word (wdata_merged); SW passes
//           wdata through; any other code returns word unchanged.
// Ports:
//   word         in  32  RAM read word
//   addr         in   2  byte offset within the word
//   funct        in   3  load or store funct code
//   wdata        in  32  right-aligned store data
//   rdata_ext    out 32  extended load result
//   wdata_merged out 32  full word to write back
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic [31:0] wdata_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    unique case (addr)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    // Halfword lane ignores addr[0]
    w_half = addr[1] ? word[31:16] : word[15:0];

    rdata_ext = '0;
    case (funct)
      F_LB:    rdata_ext = {{24{w_byte[7]}}, w_byte};
      F_LH:    rdata_ext = {{16{w_half[15]}}, w_half};
      F_LW:    rdata_ext = word;
      F_LBU:   rdata_ext = {24'd0, w_byte};
      F_LHU:   rdata_ext = {16'd0, w_half};
      default: rdata_ext = '0;
    endcase

    wdata_merged = word;
    case (funct)
      F_SB: begin
        unique case (addr)
          2'd0:    wdata_merged[7:0]   = wdata[7:0];
          2'd1:    wdata_merged[15:8]  = wdata[7:0];
          2'd2:    wdata_merged[23:16] = wdata[7:0];
          default: wdata_merged[31:24] = wdata[7:0];
        endcase
      end
      F_SH: begin
        if (addr[1]) wdata_merged[31:16] = wdata[15:0];
        else         wdata_merged[15:0]  = wdata[15:0];
      end
      F_SW:    wdata_merged = wdata;
      default: wdata_merged = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: access sequencer between the MEM stage and a dual-port data block RAM
// with a registered (one-cycle latency) read port.
//   - one request at a time; loads take 2 cycles, SW 1 cycle, SB/SH a 2-cycle
//     read-modify-write that preserves untouched lanes
//   - rsp_valid is a one-cycle completion pulse; rsp_rdata is valid only with it
// Optional feature macro: MISALIGN_CHECK_EN
//   defined  : misaligned halfword/word and unsupported funct complete via ERR with rsp_err
//   undefined: non-lane address bits are ignored, rsp_err is tied 0, no ERR state
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   req_valid/req_ready             request handshake (ready only in idle)
//   req_we, req_funct, req_addr, req_wdata   request fields
//   rsp_valid, rsp_rdata, rsp_err   response
//   mem_re, mem_raddr, mem_rdata    RAM read port
//   mem_we, mem_waddr, mem_wdata    RAM write port
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata
);

  state_e            r_state;
  logic              r_we;
  logic [2:0]        r_funct;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_mem_re;
  logic              r_mem_we;
  logic              r_rsp_valid;

  logic [31:0]       w_rdata_ext;
  logic [31:0]       w_wdata_merged;

  // Byte address bits above the RAM range carry no information here
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef MISALIGN_CHECK_EN
  logic r_rsp_err;
  logic w_req_err;
  assign w_req_err = !funct_supported(req_we, req_funct) ||
                     access_misaligned(req_funct, req_addr[1:0]);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_we        <= 1'b0;
      r_funct     <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; each is raised on the edge entering its state
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      r_rsp_err   <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_funct <= req_funct;
            r_addr  <= req_addr[ADDR_W+1:0];
            r_wdata <= req_wdata;
`ifdef MISALIGN_CHECK_EN
            if (w_req_err) begin
              r_state     <= StErr;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else
`endif
            if (!req_we) begin
              r_state  <= StRdIssue;
              r_mem_re <= 1'b1;
            end else if (req_funct == F_SW || !funct_supported(1'b1, req_funct)) begin
              // Unsupported stores still complete, but never write
              r_state     <= StWr;
              r_mem_we    <= (req_funct == F_SW);
              r_rsp_valid <= 1'b1;
            end else begin
              r_state  <= StRmwRd;
              r_mem_re <= 1'b1;
            end
          end
        end
        StRdIssue: begin
          r_state     <= StRdData;
          r_rsp_valid <= 1'b1;
        end
        StRmwRd: begin
          r_state     <= StRmwWr;
          r_mem_we    <= 1'b1;
          r_rsp_valid <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  dmem_lane_unit u_lane (
    .word         (mem_rdata),
    .addr         (r_addr[1:0]),
    .funct        (r_funct),
    .wdata        (r_wdata),
    .rdata_ext    (w_rdata_ext),
    .wdata_merged (w_wdata_merged)
  );

  assign req_ready = (r_state == StIdle);
  assign rsp_valid = r_rsp_valid;
  // RAM data arrives during RD_DATA/RMW_WR, so data paths are combinational from it
  assign rsp_rdata = (r_state == StRdData && !r_we) ? w_rdata_ext : '0;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_raddr = r_addr[ADDR_W+1:2];
  assign mem_waddr = r_addr[ADDR_W+1:2];
  assign mem_wdata = r_mem_we ? w_wdata_merged : '0;

`ifdef MISALIGN_CHECK_EN
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
